// File: rtl/ethernet_rx.sv
// ethernet_rx - RMII (2-bit) Ethernet frame receiver.
//
// Finds the preamble and SFD, assembles the 14-byte header, and filters on the
// destination MAC. The address must match my_mac or be broadcast. Accepted
// payload is then streamed out with the trailing FCS removed. The CRC-32 is
// checked against the residue, and one frame_done/frame_ok pulse reports each
// frame that got past the filter.
//
// Ports:
//   clk        50 MHz RMII reference clock
//   rst        synchronous active-high reset
//   axiiv      receive data valid (carrier) from the PHY
//   axiid      receive dibit, wire order
//   my_mac     station MAC address
//   axiov      payload dibit valid
//   axiod      payload dibit, wire order, FCS stripped
//   src_mac    source MAC of the last accepted header
//   etype      Ethernet type of the last accepted header
//   frame_done one-cycle end-of-frame pulse
//   frame_ok   frame status, valid only while frame_done=1
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | line quiet, waiting for the first preamble dibit
// PREAMBLE  | counting 01 dibits, waiting for the 11 of the SFD
// HEADER    | shifting in dest MAC, src MAC and etype (56 dibits)
// PAYLOAD   | streaming payload through the 16-dibit FCS delay line
// WAIT_IDLE | frame rejected or aborted, ignoring data until carrier drops
module ethernet_rx #(
  parameter int N         = 2,
  parameter int MAX_BYTES = 1504
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          axiiv,
  input  logic [N-1:0]  axiid,
  input  logic [47:0]   my_mac,
  output logic          axiov,
  output logic [N-1:0]  axiod,
  output logic [47:0]   src_mac,
  output logic [15:0]   etype,
  output logic          frame_done,
  output logic          frame_ok
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [12:0] MAX_DIBITS  = 13'(4 * MAX_BYTES);
  localparam logic [12:0] MIN_DIBITS  = 13'd200;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    HEADER,
    PAYLOAD,
    WAIT_IDLE
  } state_t;

  state_t        state;
  logic [4:0]    pre_cnt;
  logic [5:0]    hdr_cnt;
  logic [12:0]   pay_cnt;
  logic [31:0]   crc;
  logic [5:0]    byte_sr;   // first three dibits of the byte being assembled
  logic [103:0]  hdr;       // the first 13 completed header bytes
  logic [31:0]   dly;       // 16-dibit delay line, oldest entry in [31:30]
  logic [111:0]  hdr_full;
  logic [47:0]   hdr_dest;

  // Combined with the current dibit, this is the complete header on the 56th dibit.
  assign hdr_full = {hdr, axiid, byte_sr};
  assign hdr_dest = hdr_full[111:64];

  // Two reflected CRC steps per dibit. Bit 0 goes in first.
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? CRC_POLY : 32'h0);
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pre_cnt    <= '0;
      hdr_cnt    <= '0;
      pay_cnt    <= '0;
      crc        <= '0;
      byte_sr    <= '0;
      hdr        <= '0;
      dly        <= '0;
      axiov      <= 1'b0;
      axiod      <= '0;
      src_mac    <= '0;
      etype      <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      axiov      <= 1'b0;

      case (state)
        IDLE: begin
          if (axiiv) begin
            if (axiid == 2'b01) begin
              state   <= PREAMBLE;
              pre_cnt <= 5'd1;
            end else begin
              state <= WAIT_IDLE;
            end
          end
        end

        PREAMBLE: begin
          if (!axiiv) begin
            state <= IDLE;
          end else if (axiid == 2'b01) begin
            if (pre_cnt != 5'd31) pre_cnt <= pre_cnt + 5'd1;
          end else if (axiid == 2'b11 && pre_cnt >= 5'd8) begin
            state   <= HEADER;
            crc     <= 32'hFFFF_FFFF;
            hdr_cnt <= '0;
          end else begin
            state <= WAIT_IDLE;
          end
        end

        HEADER: begin
          if (!axiiv) begin
            // The carrier dropped inside the header, so the frame is truncated.
            frame_done <= 1'b1;
            frame_ok   <= 1'b0;
            state      <= IDLE;
          end else begin
            crc     <= crc_dibit(crc, axiid);
            byte_sr <= {axiid, byte_sr[5:2]};
            hdr_cnt <= hdr_cnt + 6'd1;
            if (hdr_cnt[1:0] == 2'b11) hdr <= {hdr[95:0], axiid, byte_sr};
            if (hdr_cnt == 6'd55) begin
              if (hdr_dest == my_mac || hdr_dest == 48'hFFFF_FFFF_FFFF) begin
                src_mac <= hdr_full[63:16];
                etype   <= hdr_full[15:0];
                pay_cnt <= '0;
                state   <= PAYLOAD;
              end else begin
                state <= WAIT_IDLE;
              end
            end
          end
        end

        PAYLOAD: begin
          if (!axiiv) begin
            // The 16 dibits left in the delay line are the FCS and are dropped.
            frame_done <= 1'b1;
            frame_ok   <= (crc == CRC_RESIDUE) && (pay_cnt[1:0] == 2'b00) &&
                          (pay_cnt >= MIN_DIBITS);
            state      <= IDLE;
          end else if (pay_cnt == MAX_DIBITS) begin
            frame_done <= 1'b1;
            frame_ok   <= 1'b0;
            state      <= WAIT_IDLE;
          end else begin
            crc     <= crc_dibit(crc, axiid);
            pay_cnt <= pay_cnt + 13'd1;
            dly     <= {dly[29:0], axiid};
            if (pay_cnt >= 13'd16) begin
              axiov <= 1'b1;
              axiod <= dly[31:30];
            end
          end
        end

        WAIT_IDLE: begin
          if (!axiiv) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ethernet_rx.md
ETHERNET_RX -- requirements
Module: ethernet_rx

Interface
REQ-001 Parameter: N, 2, bits per input beat; only N=2 is supported.
REQ-002 Parameter: MAX_BYTES, 1504, maximum payload+FCS bytes after the header.
REQ-003 clk  in  1  clock, 50 MHz RMII reference; all logic on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 axiiv  in  1  receive data valid, the clean carrier/data-valid from the PHY.
REQ-006 axiid  in  N  receive dibit, wire order (first dibit of a byte = byte bits [1:0]).
REQ-007 my_mac  in  48  MAC address of this FPGA.
REQ-008 axiov  out  1  payload dibit valid.
REQ-009 axiod  out  N  payload dibit, wire order, FCS stripped.
REQ-010 src_mac  out  48  source MAC of the last accepted header.
REQ-011 etype  out  16  Ethernet type of the last accepted header.
REQ-012 frame_done  out  1  one-cycle pulse at the end of every frame that passed address filtering.
REQ-013 frame_ok  out  1  qualifies frame_done; valid only while frame_done=1.

Function
REQ-014 States: IDLE, PREAMBLE, HEADER, PAYLOAD, WAIT_IDLE.
REQ-015 IDLE: on axiiv=1 with axiid=01, go to PREAMBLE with the preamble count = 1; axiiv=1 with any other dibit goes to WAIT_IDLE.
REQ-016 PREAMBLE: dibit 01 increments the count (saturating at 31).
REQ-017 PREAMBLE: dibit 11 with count >= 8 is the SFD; go to HEADER.
REQ-018 PREAMBLE: dibit 11 with count < 8, or any other dibit, goes to WAIT_IDLE.
REQ-019 PREAMBLE: axiiv=0 goes to IDLE.
REQ-020 Byte assembly: 4 dibits form a byte, placed LSB first; multi-byte fields are MSB-byte first (network order).
REQ-021 HEADER: consume exactly 56 dibits: dest MAC, then src MAC, then etype.
REQ-022 HEADER: src_mac and etype are shadow-captured and both update on the same edge, at the end of the 56th dibit, and only if the dest MAC matches.
REQ-023 HEADER: a dest MAC equal to my_mac or to 48'hFFFF_FFFF_FFFF is accepted and goes to PAYLOAD; any other value goes to WAIT_IDLE with no frame_done pulse.
REQ-024 HEADER: axiiv=0 before dibit 56 produces frame_done=1, frame_ok=0 on the next cycle, then IDLE.
REQ-025 CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF on SFD, 2 bits per cycle with bit 0 first, covering every dibit after the SFD including the FCS.
REQ-026 CRC pass condition: register == 32'hDEBB20E3 after the last dibit.
REQ-027 PAYLOAD: each dibit enters a 16-entry delay line.
REQ-028 PAYLOAD: once the delay line is full, each new dibit pushes out the oldest one, which is registered onto axiod with axiov=1.
REQ-029 Latency: a payload dibit sampled at edge k is presented on axiod in the cycle after edge k+16.
REQ-030 The 16 dibits still held in the delay line when axiiv falls are the FCS and are never output.
REQ-031 PAYLOAD dibit counter: 13 bits, counting payload+FCS dibits.
REQ-032 PAYLOAD end: on axiiv=0, the next cycle pulses frame_done=1 and returns to IDLE; axiov=0 from that cycle on.
REQ-033 frame_ok=1 iff the CRC passes, the dibit count is a multiple of 4, and the count is >= 200 (46-byte minimum payload + FCS).
REQ-034 Overflow: when the count exceeds 4*MAX_BYTES, pulse frame_done=1, frame_ok=0, set axiov=0, and go to WAIT_IDLE.
REQ-035 WAIT_IDLE: ignore data; on axiiv=0 go to IDLE.
REQ-036 A new frame is recognised only from IDLE; back-to-back frames need at least one cycle of axiiv=0.

Reset
REQ-037 On rst=1 at a clock edge: state=IDLE; delay line and counters cleared.
REQ-038 On rst=1 at a clock edge: axiov=0, axiod=0, frame_done=0, frame_ok=0, src_mac=0, etype=0.
REQ-039 Reset mid-frame: the remainder of that frame is not processed as a new frame, because the next frame needs a preamble and SFD.

Verification
REQ-040 Frame: 7x55 preamble, D5 SFD, dest=my_mac, src=02:00:00:00:00:01, etype=0800, 46 bytes 00..2D, correct FCS -> 184 payload dibits out in order, first one 17 cycles after its input; frame_done with frame_ok=1; src_mac, etype latched.
REQ-041 The same frame with one payload bit flipped -> identical axiod stream; frame_ok=0.
REQ-042 dest=02:00:00:00:00:99 (not my_mac, not broadcast) -> axiov never asserted; no frame_done; src_mac, etype unchanged.
REQ-043 Broadcast dest with a 20-byte payload and valid FCS -> payload output; frame_ok=0 (runt).
REQ-044 axiiv dropped after header dibit 30 -> frame_done=1, frame_ok=0 next cycle; the following good frame is received correctly.
REQ-045 rst pulsed mid-payload -> all outputs 0 next cycle; the tail of that frame is ignored; the next good frame passes with frame_ok=1.
